div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Iterative radix-2 restoring divide sequencer for the execute stage.
- Accepts one DIV/DIVU/REM/REMU request at a time, holds the execute stage via go/done, and returns a 32-bit quotient or remainder with RISC-V semantics.
- Uses the same go/done handshake as the execute-stage multiplier; the execute stage folds `go & ~done` into its stall term.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- go  input  1  request; held high while execute holds a divide op
- op  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU; sampled with go in IDLE
- a  input  32  dividend; sampled with go in IDLE
- b  input  32  divisor; sampled with go in IDLE
- ack  input  1  consumer took result (execute not stalled downstream)
- flush  input  1  abort current operation
- busy  output  1  high in any state other than IDLE
- done  output  1  result valid; high only in DONE
- result  output  32  quotient or remainder; stable while done=1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n). On reset: state=IDLE, busy=0, done=0, result=0, all internal registers cleared.
- FSM states and transitions:
  - IDLE: if go=1, latch op, sign flags, |a|, |b|, and b_zero=(b==0); clear partial remainder; iteration counter=31; next state ITER.
  - ITER: shift {rem,quo} left by 1 with the next dividend bit. Trial subtract |b|; if no borrow, keep the difference and set quo bit=1.
    - Counter decrements each cycle. After the counter==0 cycle (32 iterations total), next state FIXUP.
  - FIXUP: apply sign correction, select quotient or remainder into result; next state DONE.
  - DONE: done=1, result held. Stay until ack=1, then IDLE. go is ignored in DONE.
- Latency: go accepted at cycle N; done first high at cycle N+34. A new go may be accepted the cycle after ack.
- Sign rules (DIV/REM only):
  - Quotient negated iff sign(a)^sign(b) and b_zero=0.
  - Remainder negated iff sign(a).
  - DIVU/REMU: no correction.
- Boundary cases:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=a, for both signed and unsigned.
  - Signed overflow 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out of the magnitude datapath and needs no special path.
- flush: has priority over everything except reset. From any state, next state is IDLE, done=0, result unchanged. go in the flush cycle is not accepted.
- go deasserted mid-ITER (no flush): the operation completes and waits in DONE for ack.
- ack outside DONE: ignored.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: IDLE additionally computes lt=(|a|<|b|) and b_zero. If lt=1 and b_zero=0, the block skips ITER and goes to FIXUP with quotient=0, remainder=|a|. done is then first high at N+2. Signs still apply, so the remainder equals a.
- Not defined: every request takes the fixed 34-cycle path.

Test Plan:
- DIVU a=100, b=7, go at cycle 0: done rises cycle 34, result=14. Hold ack=0 for 3 cycles: done and result stable. ack=1: next cycle busy=0.
- REM a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFF (-1). Then DIV with the same operands, issued the cycle after ack -> 0xFFFFFFFD (-3).
- DIV a=5, b=0 -> 0xFFFFFFFF. REMU a=0x12345678, b=0 -> 0x12345678. REM a=0xFFFFFFF0, b=0 -> 0xFFFFFFF0.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Flush: DIVU issued, flush at cycle 10 -> cycle 11 busy=0, done=0. New DIVU 9/3 at cycle 11 -> done at cycle 45, result=3. reset_n=0 mid-ITER -> busy=0, done=0, result=0 next cycle.
- Early out: DIVU a=3, b=10 -> with DIV_EARLY_OUT_EN, done at cycle 2, result=0; without it, done at cycle 34, result=0. REM a=-3, b=10 -> 0xFFFFFFFD in both builds.

Source files
------------

// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-2 restoring divide sequencer (DIV/DIVU/REM/REMU, go/done handshake)
// Optional DIV_EARLY_OUT_EN: skip the iteration phase when |a| < |b| and b != 0.
module div_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            go,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            ack,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

   state_t          state;
   logic            rem_sel;
   logic            neg_q;
   logic            neg_r;
   logic [XLEN-1:0] bmag;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [4:0]      cnt;

   logic            a_neg;
   logic            b_neg;
   logic            b_is_zero;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   diff;

   // op[0] set means unsigned, so the operands are taken as-is.
   assign a_neg     = ~op[0] & a[XLEN-1];
   assign b_neg     = ~op[0] & b[XLEN-1];
   assign b_is_zero = (b == '0);
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;

   // Partial remainder stays below |b|, so bit XLEN of the difference is the borrow.
   assign rem_sh = {rem, quo[XLEN-1]};
   assign diff   = rem_sh - {1'b0, bmag};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         rem_sel <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         bmag    <= '0;
         quo     <= '0;
         rem     <= '0;
         cnt     <= '0;
      end else if (flush) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  rem_sel <= op[1];
                  neg_q   <= (a_neg ^ b_neg) & ~b_is_zero;
                  neg_r   <= a_neg;
                  bmag    <= b_mag;
                  rem     <= '0;
                  quo     <= a_mag;
                  cnt     <= 5'(XLEN - 1);
                  busy    <= 1'b1;
                  state   <= ITER;
`ifdef DIV_EARLY_OUT_EN
                  if ((a_mag < b_mag) && !b_is_zero) begin
                     quo   <= '0;
                     rem   <= a_mag;
                     state <= FIXUP;
                  end
`endif
               end
            end
            ITER: begin
               rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
               quo <= {quo[XLEN-2:0], ~diff[XLEN]};
               cnt <= cnt - 5'd1;
               if (cnt == 5'd0) begin
                  state <= FIXUP;
               end
            end
            FIXUP: begin
               if (rem_sel) begin
                  result <= neg_r ? -rem : rem;
               end else begin
                  result <= neg_q ? -quo : quo;
               end
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               if (ack) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq with a plain-arithmetic reference model
module tb_div_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        go = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        ack = 1'b0;
   logic        flush = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   div_seq #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n), .go(go), .op(op), .a(a), .b(b),
      .ack(ack), .flush(flush), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          issue;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_res = '0;
   logic        done_d = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] q, r;
      if (y == 0) begin
         q = 32'hFFFF_FFFF;
         r = x;
      end else if (!o[0]) begin
         if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x;
            r = 0;
         end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
         end
      end else begin
         q = x / y;
         r = x % y;
      end
      return o[1] ? r : q;
   endfunction

   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
      logic [31:0] mx, my;
      mx = (!o[0] && x[31]) ? -x : x;
      my = (!o[0] && y[31]) ? -y : y;
      if (y != 0 && mx < my) return 2;
`endif
      return 34;
   endfunction

   // Monitor: every rising done retires the oldest expected response.
   always @(negedge clk) begin
      if (done && !done_d) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: actual=%h required=no result pending", result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("latency", 32'(cyc - e.issue), 32'(e.lat));
            last_res = e.res;
         end
      end
      done_d = done;
   end

   task automatic wait_done();
      int k = 0;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: actual=done low after %0d cycles required=done high", k);
      end
   endtask

   // Called at a negedge; go stays high through DONE, where it must be ignored.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
      logic [31:0] r;
      r = ref_div(o, x, y);
      go = 1'b1; op = o; a = x; b = y;
      sb.push_back('{r, exp_lat(o, x, y), cyc});
      wait_done();
      repeat (hold) begin
         @(negedge clk);
         check("hold_done", {31'd0, done}, 32'd1);
         check("hold_result", result, r);
      end
      go = 1'b0;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("busy_after_ack", {31'd0, busy}, 32'd0);
      check("done_after_ack", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x, y;
      logic [1:0]  o;
      int          issue;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);

      run_op(2'd1, 32'd100, 32'd7, 3);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(2'd0, 32'd5, 32'd0, 0);
      run_op(2'd3, 32'h1234_5678, 32'd0, 0);
      run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0);
      run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'd1, 32'd3, 32'd10, 1);
      run_op(2'd2, 32'hFFFF_FFFD, 32'd10, 0);

      // Flush mid-ITER; go is already high for the next op during the flush cycle.
      go = 1'b1; op = 2'd1; a = 32'd1000; b = 32'd7;
      issue = cyc;
      @(negedge clk);
      go = 1'b0;
      while (cyc < issue + 10) @(negedge clk);
      flush = 1'b1;
      go = 1'b1; op = 2'd1; a = 32'd9; b = 32'd3;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_result", result, last_res);
      sb.push_back('{32'd3, 34, cyc});
      wait_done();
      go = 1'b0;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;

      // Reset mid-ITER clears everything, including the held result.
      go = 1'b1; op = 2'd0; a = 32'd12345; b = 32'd17;
      @(negedge clk);
      go = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_done", {31'd0, done}, 32'd0);
      check("midreset_result", result, 32'd0);

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: begin x = $urandom; y = $urandom; end
            1: begin x = $urandom_range(0, 1000); y = $urandom_range(1, 50); end
            2: begin x = $urandom; y = 32'd0; end
            3: begin x = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : $urandom; y = 32'hFFFF_FFFF; end
            default: begin x = $urandom_range(0, 20) - 10; y = $urandom_range(0, 200) - 100; end
         endcase
         run_op(o, x, y, int'($urandom_range(0, 2)));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
